// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle execute-stage ALU: op codes,
// FSM state encoding and the iterative-unit mode.
package alu_pkg;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_NOT   = 4'h4;
   localparam logic [3:0] OP_SRA   = 4'h5;
   localparam logic [3:0] OP_SLL   = 4'h6;
   localparam logic [3:0] OP_SLTU  = 4'h7;
   localparam logic [3:0] OP_ZERO  = 4'h8;
   localparam logic [3:0] OP_PASSA = 4'h9;
   localparam logic [3:0] OP_LNOT  = 4'hA;
   localparam logic [3:0] OP_NEQ   = 4'hB;
   localparam logic [3:0] OP_PASSB = 4'hC;
   localparam logic [3:0] OP_MUL   = 4'hD;
   localparam logic [3:0] OP_DIVU  = 4'hE;
   localparam logic [3:0] OP_REMU  = 4'hF;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      MD_MUL,
      MD_DIVU,
      MD_REMU
   } md_mode_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic ovf;
      logic sign;
   } flags_t;

   function automatic logic is_multicycle(input logic [3:0] op);
      return op >= OP_MUL;
   endfunction

   function automatic md_mode_t md_mode(input logic [3:0] op);
      case (op)
         OP_DIVU: return MD_DIVU;
         OP_REMU: return MD_REMU;
         default: return MD_MUL;
      endcase
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring radix-2 divide.
// One iteration per cycle, WIDTH iterations; done pulses for one cycle.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // MUL: acc = partial product, sh = multiplier (shifts right), dvs = multiplicand (shifts left).
   // DIV: acc = partial remainder, sh = dividend in / quotient out, dvs = divisor.
   logic [WIDTH-1:0] acc, sh, dvs;
   logic [WIDTH-1:0] acc_nx, sh_nx, dvs_nx;
   logic [WIDTH:0]   rs;
   logic             fits;
   logic [CW-1:0]    count;
   md_mode_t         mode_q;
   logic             busy_q, done_q;

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      acc_nx = acc;
      sh_nx  = sh;
      dvs_nx = dvs;
      rs     = {acc, sh[WIDTH-1]};
      fits   = rs >= {1'b0, dvs};
      if (mode_q == MD_MUL) begin
         if (sh[0]) acc_nx = acc + dvs;
         sh_nx  = sh >> 1;
         dvs_nx = dvs << 1;
      end else if (fits) begin
         // Trial difference is below the divisor, so the low WIDTH bits are exact.
         acc_nx = rs[WIDTH-1:0] - dvs;
         sh_nx  = {sh[WIDTH-2:0], 1'b1};
      end else begin
         acc_nx = rs[WIDTH-1:0];
         sh_nx  = {sh[WIDTH-2:0], 1'b0};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         count  <= '0;
         acc    <= '0;
         sh     <= '0;
         dvs    <= '0;
         mode_q <= MD_MUL;
      end else if (abort) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (start) begin
         busy_q <= 1'b1;
         done_q <= 1'b0;
         count  <= '0;
         acc    <= '0;
         mode_q <= md_mode_t'(mode);
         if (mode == MD_MUL) begin
            sh  <= b;
            dvs <= a;
         end else begin
            sh  <= a;
            dvs <= b;
         end
      end else if (busy_q) begin
         acc   <= acc_nx;
         sh    <= sh_nx;
         dvs   <= dvs_nx;
         count <= count + 1'b1;
         if (count == LAST) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   // A zero divisor always "fits": quotient saturates to all ones, remainder collects A.
   assign res  = (mode_q == MD_DIVU) ? sh : acc;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: valid/ready on both sides, registered
// result and flags, single-cycle ops plus iterative MUL/DIVU/REMU.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] first,
   input  logic [WIDTH-1:0] second,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zeroFlag,
   output logic             carryFlag,
   output logic             ovfFlag,
   output logic             signFlag
);

   state_t           state;
   flags_t           flags_q;
   logic             accept;
   logic             md_start, md_busy, md_done;
   logic [WIDTH-1:0] md_res;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum;
   logic [SHW-1:0]   sh;
   logic             is_addsub;
   logic [WIDTH-1:0] sc_res;
   flags_t           sc_flags;
   flags_t           md_flags;

   // Back-to-back issue is allowed from DONE when the consumer drains the held result.
   assign in_ready = rst && (state != BUSY) && !md_busy && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready && !flush;
   assign md_start = accept && is_multicycle(op);

   always_comb begin
      is_addsub = (op == OP_ADD) || (op == OP_SUB);
      b_eff     = (op == OP_SUB) ? ~second : second;
      sum       = {1'b0, first} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op == OP_SUB};
      sh        = second[SHW-1:0];
      case (op)
         OP_ADD, OP_SUB: sc_res = sum[WIDTH-1:0];
         OP_AND:         sc_res = first & second;
         OP_OR:          sc_res = first | second;
         OP_NOT:         sc_res = ~first;
         OP_SRA:         sc_res = $signed(first) >>> sh;
         OP_SLL:         sc_res = first << sh;
         OP_SLTU:        sc_res = {{(WIDTH-1){1'b0}}, first < second};
         OP_PASSA:       sc_res = first;
         OP_LNOT:        sc_res = {{(WIDTH-1){1'b0}}, first == '0};
         OP_NEQ:         sc_res = {{(WIDTH-1){1'b0}}, first != second};
         OP_PASSB:       sc_res = second;
         default:        sc_res = '0;
      endcase
      sc_flags.zero  = (sc_res == '0);
      sc_flags.carry = is_addsub && sum[WIDTH];
      sc_flags.ovf   = is_addsub && (first[WIDTH-1] == b_eff[WIDTH-1])
                                 && (sum[WIDTH-1] != first[WIDTH-1]);
      sc_flags.sign  = sc_res[WIDTH-1];

      md_flags.zero  = (md_res == '0);
      md_flags.carry = 1'b0;
      md_flags.ovf   = 1'b0;
      md_flags.sign  = md_res[WIDTH-1];
   end

   alu_iter_muldiv #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk  (clk),
      .rst  (rst),
      .start(md_start),
      .abort(flush),
      .mode (md_mode(op)),
      .a    (first),
      .b    (second),
      .busy (md_busy),
      .done (md_done),
      .res  (md_res)
   );

   // Flush wins over accept and leaves result/flags holding their last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         flags_q   <= '0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
      end else if (accept) begin
         if (is_multicycle(op)) begin
            state     <= BUSY;
            out_valid <= 1'b0;
         end else begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= sc_res;
            flags_q   <= sc_flags;
         end
      end else begin
         case (state)
            BUSY: begin
               if (md_done) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= md_res;
                  flags_q   <= md_flags;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign zeroFlag  = flags_q.zero;
   assign carryFlag = flags_q.carry;
   assign ovfFlag   = flags_q.ovf;
   assign signFlag  = flags_q.sign;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=16): reset, single-cycle ops, iterative
// ops with latency, output backpressure, flush and reset mid-operation.
module tb_alu_mc;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'h0;
   logic [15:0] first = '0;
   logic [15:0] second = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic        zeroFlag, carryFlag, ovfFlag, signFlag;
   logic [3:0]  flags_obs;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic [3:0]  f;   // {zero, carry, ovf, sign}
   } vec_t;

   vec_t sc_tab [21];
   vec_t mc_tab [7];
   vec_t hs_tab [4];

   assign flags_obs = {zeroFlag, carryFlag, ovfFlag, signFlag};

   alu_mc #(.WIDTH(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .first    (first),
      .second   (second),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .zeroFlag (zeroFlag),
      .carryFlag(carryFlag),
      .ovfFlag  (ovfFlag),
      .signFlag (signFlag)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      #12;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst out_valid: got %b want 0", out_valid); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL rst result: got %h want 0000", result); end
      n_checks++; if (flags_obs !== 4'b0000) begin n_fail++; $display("FAIL rst flags: got %b want 0000", flags_obs); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst in_ready: got %b want 0", in_ready); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release in_ready: got %b want 1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release out_valid: got %b want 0", out_valid); end
   endtask

   // Issued back-to-back: in_valid stays high, one result expected per edge.
   task automatic test_single_cycle;
      sc_tab = '{
         '{OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 4'b0011},
         '{OP_ADD,   16'hFFFF, 16'h0001, 16'h0000, 4'b1100},
         '{OP_SUB,   16'h0003, 16'h0005, 16'hFFFE, 4'b0001},
         '{OP_SUB,   16'h0005, 16'h0003, 16'h0002, 4'b0100},
         '{OP_SUB,   16'h8000, 16'h0001, 16'h7FFF, 4'b0110},
         '{OP_AND,   16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000},
         '{OP_OR,    16'hF000, 16'h000F, 16'hF00F, 4'b0001},
         '{OP_NOT,   16'h00FF, 16'h1234, 16'hFF00, 4'b0001},
         '{OP_SRA,   16'h8000, 16'h0004, 16'hF800, 4'b0001},
         '{OP_SRA,   16'h4000, 16'h0002, 16'h1000, 4'b0000},
         '{OP_SLL,   16'h0001, 16'h000F, 16'h8000, 4'b0001},
         '{OP_SLL,   16'h0001, 16'h0013, 16'h0008, 4'b0000},
         '{OP_SLTU,  16'h0001, 16'hFFFF, 16'h0001, 4'b0000},
         '{OP_SLTU,  16'hFFFF, 16'h0001, 16'h0000, 4'b1000},
         '{OP_ZERO,  16'h1234, 16'h5678, 16'h0000, 4'b1000},
         '{OP_PASSA, 16'h8001, 16'h0000, 16'h8001, 4'b0001},
         '{OP_LNOT,  16'h0000, 16'h0000, 16'h0001, 4'b0000},
         '{OP_LNOT,  16'h0005, 16'h0000, 16'h0000, 4'b1000},
         '{OP_NEQ,   16'h1234, 16'h1234, 16'h0000, 4'b1000},
         '{OP_NEQ,   16'h1234, 16'h1235, 16'h0001, 4'b0000},
         '{OP_PASSB, 16'h0000, 16'hABCD, 16'hABCD, 4'b0001}
      };
      out_ready = 1'b1;
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         op = sc_tab[i].op; first = sc_tab[i].a; second = sc_tab[i].b; in_valid = 1'b1;
         #1;
         n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sc[%0d] in_ready: got %b want 1", i, in_ready); end
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sc[%0d] out_valid: got %b want 1", i, out_valid); end
         n_checks++; if (result !== sc_tab[i].r) begin n_fail++; $display("FAIL sc[%0d] result: got %h want %h", i, result, sc_tab[i].r); end
         n_checks++; if (flags_obs !== sc_tab[i].f) begin n_fail++; $display("FAIL sc[%0d] flags: got %b want %b", i, flags_obs, sc_tab[i].f); end
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sc_drain out_valid: got %b want 0", out_valid); end
   endtask

   // Result must appear exactly at the 17th edge after the accept edge.
   task automatic test_multicycle;
      mc_tab = '{
         '{OP_MUL,  16'h0123, 16'h0010, 16'h1230, 4'b0000},
         '{OP_DIVU, 16'h0064, 16'h0007, 16'h000E, 4'b0000},
         '{OP_REMU, 16'h0064, 16'h0007, 16'h0002, 4'b0000},
         '{OP_DIVU, 16'h0005, 16'h0000, 16'hFFFF, 4'b0001},
         '{OP_REMU, 16'h0005, 16'h0000, 16'h0005, 4'b0000},
         '{OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000},
         '{OP_DIVU, 16'h0007, 16'h0064, 16'h0000, 4'b1000}
      };
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         op = mc_tab[i].op; first = mc_tab[i].a; second = mc_tab[i].b; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0; op = OP_ADD; first = 16'hDEAD; second = 16'hBEEF;
         for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 8) begin
               n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mc[%0d] busy in_ready: got %b want 0", i, in_ready); end
            end
            if (k == 16) begin
               n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mc[%0d] early out_valid: got %b want 0", i, out_valid); end
            end
         end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mc[%0d] out_valid@17: got %b want 1", i, out_valid); end
         n_checks++; if (result !== mc_tab[i].r) begin n_fail++; $display("FAIL mc[%0d] result: got %h want %h", i, result, mc_tab[i].r); end
         n_checks++; if (flags_obs !== mc_tab[i].f) begin n_fail++; $display("FAIL mc[%0d] flags: got %b want %b", i, flags_obs, mc_tab[i].f); end
      end
   endtask

   task automatic test_back_to_back;
      hs_tab = '{
         '{OP_ADD,   16'h0001, 16'h0001, 16'h0002, 4'b0000},
         '{OP_SUB,   16'h0005, 16'h0001, 16'h0004, 4'b0100},
         '{OP_OR,    16'h0008, 16'h0000, 16'h0008, 4'b0000},
         '{OP_PASSB, 16'h0000, 16'h0010, 16'h0010, 4'b0000}
      };
      @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0; op = OP_ADD; first = 16'h0001; second = 16'h0002; in_valid = 1'b1;
      @(posedge clk); #1;
      op = OP_AND; first = 16'hFFFF; second = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold[%0d] out_valid: got %b want 1", k, out_valid); end
         n_checks++; if (result !== 16'h0003) begin n_fail++; $display("FAIL hold[%0d] result: got %h want 0003", k, result); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold[%0d] in_ready: got %b want 0", k, in_ready); end
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         out_ready = 1'b1; op = hs_tab[i].op; first = hs_tab[i].a; second = hs_tab[i].b; in_valid = 1'b1;
         @(posedge clk); #1;
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b[%0d] out_valid: got %b want 1", i, out_valid); end
         n_checks++; if (result !== hs_tab[i].r) begin n_fail++; $display("FAIL b2b[%0d] result: got %h want %h", i, result, hs_tab[i].r); end
         n_checks++; if (flags_obs !== hs_tab[i].f) begin n_fail++; $display("FAIL b2b[%0d] flags: got %b want %b", i, flags_obs, hs_tab[i].f); end
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain out_valid: got %b want 0", out_valid); end
      n_checks++; if (result !== 16'h0010) begin n_fail++; $display("FAIL b2b_drain result: got %h want 0010", result); end
   endtask

   task automatic test_flush;
      logic seen;
      @(negedge clk);
      op = OP_DIVU; first = 16'h03E8; second = 16'h0003; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 7; k++) @(posedge clk);
      @(negedge clk);
      flush = 1'b1; op = OP_ADD; first = 16'h0001; second = 16'h0001; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush out_valid: got %b want 0", out_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush in_ready: got %b want 1", in_ready); end
      n_checks++; if (result !== 16'h0010) begin n_fail++; $display("FAIL flush result_hold: got %h want 0010", result); end
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush stray out_valid: got %b want 0", seen); end
      @(negedge clk);
      op = OP_ADD; first = 16'h0002; second = 16'h0003; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL post_flush out_valid: got %b want 1", out_valid); end
      n_checks++; if (result !== 16'h0005) begin n_fail++; $display("FAIL post_flush result: got %h want 0005", result); end
   endtask

   task automatic test_reset_midbusy;
      logic seen;
      @(negedge clk);
      op = OP_DIVU; first = 16'h0064; second = 16'h0007; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy out_valid: got %b want 0", out_valid); end
      n_checks++; if (result !== 16'h0000) begin n_fail++; $display("FAIL rst_busy result: got %h want 0000", result); end
      n_checks++; if (flags_obs !== 4'b0000) begin n_fail++; $display("FAIL rst_busy flags: got %b want 0000", flags_obs); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy in_ready: got %b want 0", in_ready); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_busy release in_ready: got %b want 1", in_ready); end
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         seen = seen | out_valid;
      end
      n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_busy stray out_valid: got %b want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_multicycle();
      test_back_to_back();
      test_flush();
      test_reset_midbusy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
